scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//  Parametrised binary-to-one-hot decoder with a registered output and two modes.
//  DIRECT mode: the one-hot output follows the select input with one cycle of latency.
//  SCAN mode: an internal index walks every output in turn, holding each for DWELL cycles.
//  Drives digit/row strobes and channel enables; successor of the fixed 2-to-4 decoder.
// PARAMETERS
//  IN_W   2  select width; output width OUT_W = 2**IN_W (localparam, not overridable)
//  DWELL  4  cycles each output is held in SCAN mode; legal range >= 1
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous, active-low reset
//  en     in   1      1 = outputs active; 0 = out forced to zero, state frozen
//  mode   in   1      0 = DIRECT, 1 = SCAN
//  sel    in   IN_W   DIRECT: code to decode; SCAN: start index used by load
//  load   in   1      SCAN only: restart the scan at sel (ignored in DIRECT mode)
//  out    out  OUT_W  registered one-hot output, or all zero
//  idx    out  IN_W   registered current index (the bit set in out when en=1)
//  wrap   out  1      one-cycle pulse when the SCAN index rolls from OUT_W-1 to 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): out=0, idx=0, wrap=0, dwell counter=0, state=OFF.
//  - Registered state st is one of OFF/DIR/SCN, with next state:
//    en=0 -> OFF; en=1, mode=0 -> DIR; en=1, mode=1 -> SCN.
//  - All outputs are registered; out is computed from the next-state values:
//    out <= (st_next==OFF) ? 0 : (1 << idx_next). Latency is 1 clk from any input.
//  - OFF: idx and the dwell counter hold their values; wrap=0; out=0.
//  - DIR: idx <= sel; dwell counter <= 0; wrap=0.
//  - SCN, counter width max(1, clog2(DWELL)):
//    - load=1: idx <= sel, counter <= 0, wrap=0. load takes priority over advance.
//    - else if counter==DWELL-1: counter <= 0 and idx <= idx+1 modulo OUT_W.
//      wrap <= 1 only when idx was OUT_W-1.
//    - else: counter <= counter+1, idx held, wrap=0.
//    - DWELL=1: idx advances every cycle and the counter stays 0.
//  - Entering SCN from DIR or OFF: the scan continues from the current idx.
//    The counter keeps its value from OFF, or is 0 when coming from DIR.
//  - Leaving SCN to DIR: idx is taken from sel on that same edge; the counter clears.
//  - en=0 mid-scan freezes the position. Re-enabling resumes the same output
//    with the remaining dwell.
//  - Reset asserted mid-scan: everything clears immediately, without waiting for clk.
//  - out is guaranteed one-hot or zero in every state; no multi-hot value is possible.
//  - Arithmetic: idx increment wraps naturally at IN_W bits. The dwell compare is
//    exact (==). There is no overflow path.
// TESTING (IN_W=2, DWELL=4 unless noted)
//  1 Reset: hold rst_n=0 with en=1 and sel=3 -> out=0000, idx=0, wrap=0.
//    Release rst_n -> out=1000 after 1 clk.
//  2 DIRECT: en=1, mode=0, sel=0,1,2,3 in consecutive cycles.
//    -> out=0001,0010,0100,1000, each 1 clk after its sel.
//  3 SCAN: from idx=0, set mode=1 -> out=0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
//    wrap=1 for exactly the 1 clk in which out returns to 0001.
//  4 load: in SCAN at idx=1 with counter=2, pulse load with sel=3.
//    -> next clk out=1000; it holds 4 clks; wrap pulses on the move to 0001.
//  5 Freeze: in SCAN at idx=2 after 1 dwell cycle, drop en for 5 clks -> out=0000.
//    Raise en -> out=0100 for 3 more clks, then 1000.
//  6 Async reset mid-scan (DWELL=1): assert rst_n between clock edges.
//    -> out=0, idx=0 before the next edge.
//    Release -> scan restarts at 0001 and advances every clk.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: binary-to-one-hot decoder with registered outputs.
// DIRECT mode decodes sel with one cycle of latency; SCAN mode walks an
// internal index across every output, holding each one for DWELL cycles.
// en=0 blanks the output and freezes the scan position and dwell count.
module scan_decoder #(
    parameter int IN_W  = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [IN_W-1:0]        sel,
    input  logic                   load,
    output logic [(1<<IN_W)-1:0]   out,
    output logic [IN_W-1:0]        idx,
    output logic                   wrap
);

    localparam int OUT_W = 1 << IN_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IN_W-1:0]  IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_DIR = 2'd1,
        ST_SCN = 2'd2
    } state_e;

    state_e             st_q,   st_d;
    logic [IN_W-1:0]    idx_q,  idx_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [OUT_W-1:0]   out_q,  out_d;
    logic               wrap_q, wrap_d;

    // Next state, index, dwell count and outputs, all from the current inputs.
    always_comb begin
        st_d   = ST_OFF;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;

        if (en) begin
            st_d = mode ? ST_SCN : ST_DIR;
        end

        case (st_d)
            ST_DIR: begin
                idx_d = sel;
                cnt_d = '0;
            end
            ST_SCN: begin
                if (load) begin
                    idx_d = sel;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // OFF: index and dwell count hold so a later re-enable resumes.
                idx_d = idx_q;
                cnt_d = cnt_q;
            end
        endcase

        // Output is decoded from the next index, so it is one-hot or zero only.
        out_d = (st_d == ST_OFF) ? '0 : (OUT_W'(1) << idx_d);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_OFF;
            idx_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed tests for scan_decoder, one task per scenario.
// u_dut uses DWELL=4; u_dut1 uses DWELL=1 for the async-reset scan case.
module tb_scan_decoder;

    logic       clk;
    logic       rst_n, en, mode, load;
    logic [1:0] sel;
    logic [3:0] out;
    logic [1:0] idx;
    logic       wrap;

    logic       rst1_n, en1, mode1, load1;
    logic [1:0] sel1;
    logic [3:0] out1;
    logic [1:0] idx1;
    logic       wrap1;

    int checks;
    int errors;

    scan_decoder #(.IN_W(2), .DWELL(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .out   (out),
        .idx   (idx),
        .wrap  (wrap)
    );

    scan_decoder #(.IN_W(2), .DWELL(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .en    (en1),
        .mode  (mode1),
        .sel   (sel1),
        .load  (load1),
        .out   (out1),
        .idx   (idx1),
        .wrap  (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        sel   = 2'd3;
        load  = 1'b0;
        tick();
        tick();
        checks++;
        if (out !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out=%b idx=%0d wrap=%b, want out=0000 idx=0 wrap=0", out, idx, wrap);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_release: out=%b idx=%0d, want out=1000 idx=3", out, idx);
        end
    endtask

    task automatic test_direct();
        logic [3:0] e;
        mode = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            e = 4'(1 << i);
            checks++;
            if (out !== e || idx !== 2'(i) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL direct sel=%0d: out=%b idx=%0d wrap=%b, want out=%b idx=%0d wrap=0", i, out, idx, wrap, e, i);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] e;
        logic       ew;
        mode = 1'b0;
        sel  = 2'd0;
        tick();
        checks++;
        if (out !== 4'b0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL scan_start: out=%b wrap=%b, want out=0001 wrap=0", out, wrap);
        end
        mode = 1'b1;
        for (int unsigned k = 1; k <= 17; k++) begin
            tick();
            e  = 4'(1 << ((k / 4) % 4));
            ew = (k == 16);
            checks++;
            if (out !== e || wrap !== ew) begin
                errors++;
                $display("FAIL scan k=%0d: out=%b wrap=%b, want out=%b wrap=%b", k, out, wrap, e, ew);
            end
        end
    endtask

    task automatic test_load();
        // scan position after test_scan: idx=0, count=1; five more edges give idx=1, count=2
        for (int unsigned i = 0; i < 5; i++) tick();
        checks++;
        if (out !== 4'b0010 || idx !== 2'd1) begin
            errors++;
            $display("FAIL load_pre: out=%b idx=%0d, want out=0010 idx=1", out, idx);
        end
        sel  = 2'd3;
        load = 1'b1;
        tick();
        load = 1'b0;
        sel  = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (out !== 4'b1000 || idx !== 2'd3 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_hold c=%0d: out=%b idx=%0d wrap=%b, want out=1000 idx=3 wrap=0", i, out, idx, wrap);
            end
            tick();
        end
        checks++;
        if (out !== 4'b0001 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap: out=%b wrap=%b, want out=0001 wrap=1", out, wrap);
        end
        tick();
        checks++;
        if (out !== 4'b0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_after: out=%b wrap=%b, want out=0001 wrap=0", out, wrap);
        end
    endtask

    task automatic test_freeze();
        // idx=0, count=1 now; seven edges reach idx=2 with count=0
        for (int unsigned i = 0; i < 7; i++) tick();
        checks++;
        if (out !== 4'b0100 || idx !== 2'd2) begin
            errors++;
            $display("FAIL freeze_pre: out=%b idx=%0d, want out=0100 idx=2", out, idx);
        end
        en = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out !== 4'b0000 || idx !== 2'd2 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL freeze_off c=%0d: out=%b idx=%0d wrap=%b, want out=0000 idx=2 wrap=0", i, out, idx, wrap);
            end
        end
        en = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 4'b0100) begin
                errors++;
                $display("FAIL freeze_resume c=%0d: out=%b, want out=0100", i, out);
            end
        end
        tick();
        checks++;
        if (out !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL freeze_next: out=%b idx=%0d, want out=1000 idx=3", out, idx);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        en1   = 1'b1;
        mode1 = 1'b1;
        sel1  = 2'd0;
        load1 = 1'b1;
        rst1_n = 1'b1;
        tick();
        load1 = 1'b0;
        tick();
        tick();
        checks++;
        if (out1 !== 4'b0100 || idx1 !== 2'd2) begin
            errors++;
            $display("FAIL async_pre: out=%b idx=%0d, want out=0100 idx=2", out1, idx1);
        end
        #2;
        rst1_n = 1'b0;
        #1;
        checks++;
        if (out1 !== 4'b0000 || idx1 !== 2'd0 || wrap1 !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: out=%b idx=%0d wrap=%b, want out=0000 idx=0 wrap=0", out1, idx1, wrap1);
        end
        rst1_n = 1'b1;
        load1  = 1'b1;
        tick();
        load1 = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            e = 4'(1 << (k % 4));
            checks++;
            if (out1 !== e || wrap1 !== (k == 4)) begin
                errors++;
                $display("FAIL async_scan k=%0d: out=%b wrap=%b, want out=%b wrap=%b", k, out1, wrap1, e, (k == 4));
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        en = 1'b0; mode = 1'b0; sel = 2'd0; load = 1'b0;
        en1 = 1'b0; mode1 = 1'b0; sel1 = 2'd0; load1 = 1'b0;
        #1;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        test_reset();
        test_direct();
        test_scan();
        test_load();
        test_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
